// File: rtl/uart_rx_frame_ctrl_if.sv
// Signal bundle between the UART receive frame controller and its surroundings
// (serial line, frame configuration, bit-timing counter and received-data outputs).
interface uart_rx_frame_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESC_W    = 6
);
  logic                  RX_IN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [PRESC_W-1:0]    Prescale;
  logic [PRESC_W-1:0]    edge_cnt;
  logic [4:0]            bit_cnt;
  logic                  cnt_enable;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;
  logic                  busy;

  // Frame controller side
  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP, Prescale, edge_cnt, bit_cnt,
    output cnt_enable, P_DATA, data_valid, par_err, stp_err, busy
  );

  // Line / counter / consumer side
  modport master (
    output RX_IN, PAR_EN, PAR_TYP, Prescale, edge_cnt, bit_cnt,
    input  cnt_enable, P_DATA, data_valid, par_err, stp_err, busy
  );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start detection, 3-sample majority voting at
// mid-bit, LSB-first deserialisation, parity/stop checking and result strobes.
// Optional macro UART_RX_SYNC_EN adds a 2-flop synchroniser on RX_IN.
module uart_rx_frame_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESC_W    = 6
) (
  input logic                 CLK,
  input logic                 RST,
  uart_rx_frame_ctrl_if.slave bus
);

  localparam int unsigned BIT_CNT_W = 5;
  localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = BIT_CNT_W'(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [2:0]            samp_q, samp_d;
  logic                  par_bad_q, par_bad_d;
  logic                  stp_bad_q, stp_bad_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  dv_q, dv_d;
  logic                  pe_q, pe_d;
  logic                  se_q, se_d;
  logic                  cnt_en_q, cnt_en_d;
  logic                  busy_q, busy_d;

  logic                  rx;
  logic [PRESC_W-1:0]    half;
  logic                  at_s0, at_s1, at_s2, at_dec, at_last;
  logic                  decision;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchroniser, idles high so reset does not look like a start bit
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) sync_q <= 2'b11;
    else      sync_q <= {sync_q[0], bus.RX_IN};
  end

  assign rx = sync_q[1];
`else
  assign rx = bus.RX_IN;
`endif

  // Sample/decision points relative to the latched prescale
  assign half     = presc_q >> 1;
  assign at_s0    = (bus.edge_cnt == PRESC_W'(half - PRESC_W'(1)));
  assign at_s1    = (bus.edge_cnt == half);
  assign at_s2    = (bus.edge_cnt == PRESC_W'(half + PRESC_W'(1)));
  assign at_dec   = (bus.edge_cnt == PRESC_W'(half + PRESC_W'(2)));
  assign at_last  = (bus.edge_cnt == PRESC_W'(presc_q - PRESC_W'(1)));
  assign decision = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);

  // State and datapath registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      shift_q   <= '0;
      samp_q    <= '0;
      par_bad_q <= 1'b0;
      stp_bad_q <= 1'b0;
      p_data_q  <= '0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;
      cnt_en_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      shift_q   <= shift_d;
      samp_q    <= samp_d;
      par_bad_q <= par_bad_d;
      stp_bad_q <= stp_bad_d;
      p_data_q  <= p_data_d;
      dv_q      <= dv_d;
      pe_q      <= pe_d;
      se_q      <= se_d;
      cnt_en_q  <= cnt_en_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state, sampling and output decode; outputs registered from next-state values
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    shift_d   = shift_q;
    samp_d    = samp_q;
    par_bad_d = par_bad_q;
    stp_bad_d = stp_bad_q;
    p_data_d  = p_data_q;
    dv_d      = 1'b0;
    pe_d      = 1'b0;
    se_d      = 1'b0;

    if (state_q != S_IDLE) begin
      if (at_s0) samp_d[0] = rx;
      if (at_s1) samp_d[1] = rx;
      if (at_s2) samp_d[2] = rx;
    end

    case (state_q)
      S_IDLE: begin
        if (!rx) begin
          state_d   = S_START;
          presc_d   = bus.Prescale;
          par_en_d  = bus.PAR_EN;
          par_typ_d = bus.PAR_TYP;
        end
      end
      S_START: begin
        if (at_dec && decision) state_d = S_IDLE;
        else if (at_last)       state_d = S_DATA;
      end
      S_DATA: begin
        if (at_dec) shift_d = {decision, shift_q[DATA_WIDTH-1:1]};
        if (at_last && (bus.bit_cnt == LAST_DATA_BIT))
          state_d = par_en_q ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (at_dec)  par_bad_d = (decision != ((^shift_q) ^ par_typ_q));
        if (at_last) state_d   = S_STOP;
      end
      S_STOP: begin
        if (at_dec) begin
          stp_bad_d = !decision;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        par_bad_d = 1'b0;
        stp_bad_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    // Result strobes appear in the DONE cycle
    if (state_d == S_DONE) begin
      pe_d = par_bad_d;
      se_d = stp_bad_d;
      dv_d = !(par_bad_d || stp_bad_d);
      if (dv_d) p_data_d = shift_d;
    end

    cnt_en_d = (state_d == S_START) || (state_d == S_DATA) ||
               (state_d == S_PARITY) || (state_d == S_STOP);
    busy_d   = (state_d != S_IDLE);
  end

  assign bus.cnt_enable = cnt_en_q;
  assign bus.P_DATA     = p_data_q;
  assign bus.data_valid = dv_q;
  assign bus.par_err    = pe_q;
  assign bus.stp_err    = se_q;
  assign bus.busy       = busy_q;

endmodule
